sqrt_pipe_collector: RTL and testbench

Tail-end reader for the 8-bit square-root pipeline. It takes the Stage-4 register outputs (ready flag, 13-bit square sum, square carry, A/B high nibbles) and packs each valid token into a small result FIFO. Results leave through a valid/ready handshake. The block owns the pipeline-wide enable `en_pipe_o`, and freezes every stage whenever the FIFO cannot accept the token leaving Stage 4, so no result is ever dropped.

---
 rtl/sqrt_pipe_collector.sv | 92 +++++++++
 tb/tb_sqrt_pipe_collector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pipe_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sqrt_pipe_collector: packs Stage-4 sqrt tokens into a result FIFO and      |
// | stalls the whole pipeline when the FIFO cannot take the outgoing token.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sqrt_pipe_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic             en_pipe_o,
  input  logic             S4_ready_i,
  input  logic [12:0]      S4_square_sum_i,
  input  logic             S4_Co_square_i,
  input  logic [3:0]       S4_A_high_i,
  input  logic [3:0]       S4_B_high_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [12:0]      res_square_sum_o,
  output logic             res_Co_square_o,
  output logic [3:0]       res_A_high_o,
  output logic [3:0]       res_B_high_o,
  output logic             full_o,
  output logic [CNT_W-1:0] res_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WORD_W = 22;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic              push, pop;
  logic [WORD_W-1:0] wr_word, rd_word;

  assign res_valid_o = (count_q != '0);
  assign full_o      = (count_q == C_FULL);
  assign pop         = res_valid_o & res_ready_i;
  // A pop frees a slot this very edge, so a full FIFO can still accept.
  assign en_pipe_o   = en_i & (~full_o | pop);
  assign push        = en_pipe_o & S4_ready_i;

  assign wr_word = {S4_Co_square_i, S4_square_sum_i, S4_A_high_i, S4_B_high_i};
  assign rd_word = mem_q[rd_ptr_q];

  assign res_Co_square_o  = rd_word[21];
  assign res_square_sum_o = rd_word[20:8];
  assign res_A_high_o     = rd_word[7:4];
  assign res_B_high_o     = rd_word[3:0];
  assign res_count_o      = res_count_q;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    res_count_d = pop ? res_count_q + CNT_W'(1) : res_count_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_count_q <= res_count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_pipe_collector.sv
`default_nettype none
// Directed self-checking bench for sqrt_pipe_collector (DEPTH=4, CNT_W=4).
module tb_sqrt_pipe_collector;

  logic        clk = 1'b0;
  logic        rst, en_i, en_pipe_o;
  logic        S4_ready_i, S4_Co_square_i;
  logic [12:0] S4_square_sum_i;
  logic [3:0]  S4_A_high_i, S4_B_high_i;
  logic        res_valid_o, res_ready_i, res_Co_square_o, full_o;
  logic [12:0] res_square_sum_o;
  logic [3:0]  res_A_high_o, res_B_high_o;
  logic [3:0]  res_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt_pipe_collector #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .en_pipe_o(en_pipe_o),
    .S4_ready_i(S4_ready_i), .S4_square_sum_i(S4_square_sum_i),
    .S4_Co_square_i(S4_Co_square_i), .S4_A_high_i(S4_A_high_i),
    .S4_B_high_i(S4_B_high_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_square_sum_o(res_square_sum_o),
    .res_Co_square_o(res_Co_square_o), .res_A_high_o(res_A_high_o),
    .res_B_high_o(res_B_high_o), .full_o(full_o), .res_count_o(res_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tok(input logic v, input logic co, input logic [12:0] s,
                     input logic [3:0] a, input logic [3:0] b);
    S4_ready_i = v; S4_Co_square_i = co; S4_square_sum_i = s;
    S4_A_high_i = a; S4_B_high_i = b;
  endtask

  function automatic logic [31:0] word(input logic co, input logic [12:0] s,
                                       input logic [3:0] a, input logic [3:0] b);
    return {10'd0, co, s, a, b};
  endfunction

  function automatic logic [31:0] head();
    return {10'd0, res_Co_square_o, res_square_sum_o, res_A_high_o, res_B_high_o};
  endfunction

  task automatic chk_head(input string tag, input logic [31:0] exp);
    #1;
    chk({tag, "_valid"}, 32'(res_valid_o), 32'd1);
    chk(tag, head(), exp);
  endtask

  logic [3:0] kk;

  initial begin
    rst = 1'b1; en_i = 1'b1; res_ready_i = 1'b0;
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);

    // Reset
    tick; tick;
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_count", 32'(res_count_o), 32'd0);
    chk("rst_en_pipe", 32'(en_pipe_o), 32'd1);
    rst = 1'b0;

    // Streaming: token k shows at the head one cycle after it is presented
    res_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      kk = 4'(k);
      tok(1'b1, kk[0], 13'h0010 + 13'(k), kk, 4'd15 - kk);
      #1;
      chk("stream_en_pipe", 32'(en_pipe_o), 32'd1);
      if (k > 0) begin
        kk = 4'(k - 1);
        chk_head("stream_head", word(kk[0], 13'h0010 + 13'(k - 1), kk, 4'd15 - kk));
      end else begin
        chk("stream_first_empty", 32'(res_valid_o), 32'd0);
      end
      tick;
    end
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);
    chk_head("stream_last", word(1'b1, 13'h0017, 4'd7, 4'd8));
    tick;
    chk("stream_drained", 32'(res_valid_o), 32'd0);
    chk("stream_count", 32'(res_count_o), 32'd8);

    // Back-pressure
    res_ready_i = 1'b0;
    tok(1'b1, 1'b0, 13'h1ABC, 4'h1, 4'hE); #1; chk("bp_en0", 32'(en_pipe_o), 32'd1); tick;
    tok(1'b1, 1'b1, 13'h0001, 4'h2, 4'hD); #1; chk("bp_en1", 32'(en_pipe_o), 32'd1); tick;
    tok(1'b1, 1'b0, 13'h1FFF, 4'h3, 4'hC); #1; chk("bp_en2", 32'(en_pipe_o), 32'd1); tick;
    tok(1'b1, 1'b1, 13'h0800, 4'h4, 4'hB); #1; chk("bp_en3", 32'(en_pipe_o), 32'd1); tick;
    tok(1'b1, 1'b0, 13'h0555, 4'h5, 4'hA); #1;
    chk("bp_full", 32'(full_o), 32'd1);
    chk("bp_en_stall", 32'(en_pipe_o), 32'd0);
    tick;
    chk("bp_full_hold", 32'(full_o), 32'd1);
    chk("bp_en_hold", 32'(en_pipe_o), 32'd0);
    chk_head("bp_head_held", word(1'b0, 13'h1ABC, 4'h1, 4'hE));
    res_ready_i = 1'b1; #1;
    chk("bp_en_release", 32'(en_pipe_o), 32'd1);
    tick;
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);
    #1; chk("bp_full_swap", 32'(full_o), 32'd1);
    chk_head("bp_h1", word(1'b1, 13'h0001, 4'h2, 4'hD)); tick;
    chk_head("bp_h2", word(1'b0, 13'h1FFF, 4'h3, 4'hC)); tick;
    chk_head("bp_h3", word(1'b1, 13'h0800, 4'h4, 4'hB)); tick;
    chk_head("bp_h4", word(1'b0, 13'h0555, 4'h5, 4'hA)); tick;
    chk("bp_drained", 32'(res_valid_o), 32'd0);
    chk("bp_count", 32'(res_count_o), 32'd13);

    // Bubbles: only the valid tokens get stored
    res_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) tok(1'b1, 1'b0, 13'h0AAA + 13'(k / 2) * 13'h0111, 4'(k), 4'h0);
      else            tok(1'b0, 1'b1, 13'h1FFF, 4'hF, 4'hF);
      tick;
    end
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);
    #1; chk("bub_not_full", 32'(full_o), 32'd0);
    res_ready_i = 1'b1;
    chk_head("bub_h0", word(1'b0, 13'h0AAA, 4'd0, 4'h0)); tick;
    chk_head("bub_h1", word(1'b0, 13'h0BBB, 4'd2, 4'h0)); tick;
    chk_head("bub_h2", word(1'b0, 13'h0CCC, 4'd4, 4'h0)); tick;
    chk("bub_drained", 32'(res_valid_o), 32'd0);
    chk("bub_count_wrap", 32'(res_count_o), 32'd0);

    // Freeze and drain
    res_ready_i = 1'b0;
    tok(1'b1, 1'b0, 13'h0111, 4'h1, 4'h1); tick;
    tok(1'b1, 1'b0, 13'h0222, 4'h2, 4'h2); tick;
    en_i = 1'b0; res_ready_i = 1'b1;
    tok(1'b1, 1'b1, 13'h0333, 4'h3, 4'h3);
    #1; chk("frz_en_pipe", 32'(en_pipe_o), 32'd0);
    chk_head("frz_h0", word(1'b0, 13'h0111, 4'h1, 4'h1)); tick;
    chk_head("frz_h1", word(1'b0, 13'h0222, 4'h2, 4'h2)); tick;
    #1; chk("frz_empty", 32'(res_valid_o), 32'd0); tick;
    #1; chk("frz_no_push", 32'(res_valid_o), 32'd0);
    chk("frz_count", 32'(res_count_o), 32'd2);
    en_i = 1'b1;
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);

    // Mid-operation reset discards queued entries
    res_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tok(1'b1, 1'b0, 13'h0A00 + 13'(k), 4'(k), 4'(k));
      tick;
    end
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);
    #1; chk("mid_pre_valid", 32'(res_valid_o), 32'd1);
    rst = 1'b1; tick; rst = 1'b0;
    #1; chk("mid_valid", 32'(res_valid_o), 32'd0);
    chk("mid_count", 32'(res_count_o), 32'd0);

    // 17 pops on a 4-bit counter wraps to 1
    res_ready_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tok(1'b1, 1'b0, 13'(k), 4'h0, 4'h0);
      tick;
    end
    tok(1'b0, 1'b0, 13'h0, 4'h0, 4'h0);
    chk_head("wrap_last", word(1'b0, 13'd16, 4'h0, 4'h0)); tick;
    #1; chk("wrap_count", 32'(res_count_o), 32'd1);
    chk("wrap_drained", 32'(res_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
